// File: rtl/can_frame_gen.sv
// can_frame_gen: serializes one buffered CAN 2.0A frame per start request.
// The frame is snapshotted from tx_buff on frame_gen_intl, then driven one bit
// per bit_tick on tx_bit. The frame covers SOF, arbitration, control, data,
// CRC-15, bit stuffing, ACK slot, EOF and intermission. There is no retransmission.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-low reset
//   bit_tick             one-cycle strobe per CAN bit time
//   frame_gen_intl       start request, honoured only in IDLE
//   tx_buff_1            ID[10:3]
//   tx_buff_2            [7:5] = ID[2:0]; [4:0] unused
//   tx_buff_3..10        data bytes 0..7, byte 0 sent first
//   rtr, dlc             remote flag and data length code
//   rx_bit               bus readback, sampled at the end of the ACK slot
//   tx_bit               serial bit, 1 = recessive (registered)
//   frame_gen_busy       high from capture until return to IDLE
//   tx_success/ack_err   one-cycle completion pulses (ACKed / not ACKed)
module can_frame_gen #(
  parameter int IFS_BITS = 3,
  parameter int EOF_BITS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       frame_gen_intl,
  input  logic [7:0] tx_buff_1,
  input  logic [7:0] tx_buff_2,
  input  logic [7:0] tx_buff_3,
  input  logic [7:0] tx_buff_4,
  input  logic [7:0] tx_buff_5,
  input  logic [7:0] tx_buff_6,
  input  logic [7:0] tx_buff_7,
  input  logic [7:0] tx_buff_8,
  input  logic [7:0] tx_buff_9,
  input  logic [7:0] tx_buff_10,
  input  logic       rtr,
  input  logic [3:0] dlc,
  input  logic       rx_bit,
  output logic       tx_bit,
  output logic       frame_gen_busy,
  output logic       tx_success,
  output logic       ack_err
);

  // Each state names the field whose next bit goes out on the coming bit_tick.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SOF      = 4'd1;
  localparam logic [3:0] S_ID       = 4'd2;
  localparam logic [3:0] S_CTRL     = 4'd3;
  localparam logic [3:0] S_DATA     = 4'd4;
  localparam logic [3:0] S_CRC      = 4'd5;
  localparam logic [3:0] S_CRC_DEL  = 4'd6;
  localparam logic [3:0] S_ACK_SLOT = 4'd7;
  localparam logic [3:0] S_ACK_DEL  = 4'd8;
  localparam logic [3:0] S_EOF      = 4'd9;
  localparam logic [3:0] S_IFS      = 4'd10;

  localparam logic [3:0] EOF_LAST = 4'(EOF_BITS - 1);
  // IFS counts emitted bits; one extra tick ends the last one.
  localparam logic [3:0] IFS_DONE = 4'(IFS_BITS);

  // One CRC-15 step (poly 0x4599) for a single unstuffed bit.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  logic [3:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  byte_q, byte_d;
  logic [10:0] id_q, id_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [7:0]  data_q [8];
  logic [7:0]  data_d [8];
  logic [14:0] crc_q, crc_d;
  logic [2:0]  run_q, run_d;
  logic        last_q, last_d;
  logic        ack_ok_q, ack_ok_d;
  logic        tx_bit_q, tx_bit_d;
  logic        busy_q, busy_d;
  logic        success_q, success_d;
  logic        err_q, err_d;

  logic [3:0]  n_bytes_s;
  logic        field_bit_s;
  logic        stuff_zone_s;
  logic        stuff_now_s;
  logic        crc_zone_s;
  logic        unused_ok_s;

  assign unused_ok_s = ^tx_buff_2[4:0];

  // Data byte count: remote frames carry none, DLC above 8 is clamped to 8.
  assign n_bytes_s = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);

  // Stuffing spans SOF..CRC; CRC_DEL is included so a stuff bit can follow the last CRC bit.
  assign stuff_zone_s = (state_q >= S_SOF) && (state_q <= S_CRC_DEL);
  assign stuff_now_s  = stuff_zone_s && (run_q == 3'd5);
  assign crc_zone_s   = (state_q >= S_SOF) && (state_q <= S_DATA);

  // Unstuffed bit for the current field position.
  always_comb begin
    field_bit_s = 1'b1;
    case (state_q)
      S_SOF:  field_bit_s = 1'b0;
      S_ID:   field_bit_s = id_q[4'd10 - cnt_q];
      S_CTRL: begin
        case (cnt_q)
          4'd0:    field_bit_s = rtr_q;
          4'd1:    field_bit_s = 1'b0;
          4'd2:    field_bit_s = 1'b0;
          4'd3:    field_bit_s = dlc_q[3];
          4'd4:    field_bit_s = dlc_q[2];
          4'd5:    field_bit_s = dlc_q[1];
          4'd6:    field_bit_s = dlc_q[0];
          default: field_bit_s = 1'b0;
        endcase
      end
      S_DATA:  field_bit_s = data_q[byte_q][3'd7 - cnt_q[2:0]];
      S_CRC:   field_bit_s = crc_q[4'd14 - cnt_q];
      default: field_bit_s = 1'b1;
    endcase
  end

  // Next-state, shadow capture, stuffing, CRC and completion logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    id_d      = id_q;
    rtr_d     = rtr_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    crc_d     = crc_q;
    run_d     = run_q;
    last_d    = last_q;
    ack_ok_d  = ack_ok_q;
    tx_bit_d  = tx_bit_q;
    success_d = 1'b0;
    err_d     = 1'b0;

    if (state_q == S_IDLE) begin
      // A bit_tick on the capture edge is deliberately ignored.
      if (frame_gen_intl) begin
        id_d      = {tx_buff_1, tx_buff_2[7:5]};
        rtr_d     = rtr;
        dlc_d     = dlc;
        data_d[0] = tx_buff_3;
        data_d[1] = tx_buff_4;
        data_d[2] = tx_buff_5;
        data_d[3] = tx_buff_6;
        data_d[4] = tx_buff_7;
        data_d[5] = tx_buff_8;
        data_d[6] = tx_buff_9;
        data_d[7] = tx_buff_10;
        state_d   = S_SOF;
        cnt_d     = 4'd0;
        byte_d    = 3'd0;
        crc_d     = 15'h0000;
        run_d     = 3'd0;
        last_d    = 1'b1;
        ack_ok_d  = 1'b0;
        tx_bit_d  = 1'b1;
      end else begin
        tx_bit_d = 1'b1;
      end
    end else if (bit_tick) begin
      if (stuff_now_s) begin
        // Stuff bit: complement of the run, starts a new run, fields and CRC hold.
        tx_bit_d = ~last_q;
        last_d   = ~last_q;
        run_d    = 3'd1;
      end else begin
        tx_bit_d = field_bit_s;
        if (stuff_zone_s) begin
          if (field_bit_s == last_q) begin
            run_d = run_q + 3'd1;
          end else begin
            run_d = 3'd1;
          end
          last_d = field_bit_s;
        end else begin
          run_d  = 3'd0;
          last_d = last_q;
        end
        if (crc_zone_s) begin
          crc_d = crc15_step(crc_q, field_bit_s);
        end else begin
          crc_d = crc_q;
        end

        case (state_q)
          S_SOF: begin
            state_d = S_ID;
            cnt_d   = 4'd0;
          end
          S_ID: begin
            if (cnt_q == 4'd10) begin
              state_d = S_CTRL;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_CTRL: begin
            if (cnt_q == 4'd6) begin
              cnt_d   = 4'd0;
              byte_d  = 3'd0;
              state_d = (n_bytes_s == 4'd0) ? S_CRC : S_DATA;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_DATA: begin
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if ({1'b0, byte_q} == (n_bytes_s - 4'd1)) begin
                state_d = S_CRC;
              end else begin
                byte_d = byte_q + 3'd1;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_CRC: begin
            if (cnt_q == 4'd14) begin
              state_d = S_CRC_DEL;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_CRC_DEL:  state_d = S_ACK_SLOT;
          S_ACK_SLOT: state_d = S_ACK_DEL;
          S_ACK_DEL: begin
            // This tick ends the ACK slot: a dominant readback means acknowledged.
            ack_ok_d = ~rx_bit;
            state_d  = S_EOF;
            cnt_d    = 4'd0;
          end
          S_EOF: begin
            if (cnt_q == EOF_LAST) begin
              state_d = S_IFS;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_IFS: begin
            if (cnt_q == IFS_DONE) begin
              state_d   = S_IDLE;
              cnt_d     = 4'd0;
              success_d = ack_ok_q;
              err_d     = ~ack_ok_q;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end else begin
      tx_bit_d = tx_bit_q;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      byte_q    <= 3'd0;
      id_q      <= 11'd0;
      rtr_q     <= 1'b0;
      dlc_q     <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= 8'h00;
      end
      crc_q     <= 15'h0000;
      run_q     <= 3'd0;
      last_q    <= 1'b1;
      ack_ok_q  <= 1'b0;
      tx_bit_q  <= 1'b1;
      busy_q    <= 1'b0;
      success_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      id_q      <= id_d;
      rtr_q     <= rtr_d;
      dlc_q     <= dlc_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      run_q     <= run_d;
      last_q    <= last_d;
      ack_ok_q  <= ack_ok_d;
      tx_bit_q  <= tx_bit_d;
      busy_q    <= busy_d;
      success_q <= success_d;
      err_q     <= err_d;
    end
  end

  assign tx_bit         = tx_bit_q;
  assign frame_gen_busy = busy_q;
  assign tx_success     = success_q;
  assign ack_err        = err_q;

endmodule
